square_unit_pipe: RTL and testbench

Parametrised per-square move-generation cell for the systolic board array. It replaces the fixed 8x8 white-only cell and supports a configurable board size and either side to move. Moves are buffered in an internal 8-slot pending bank and drained over a valid/ready port instead of a wide FIFO write. One instance sits at each board square; an array controller broadcasts `start` and `step` to every cell.

---
 rtl/square_unit_pipe_if.sv | 12 +
 rtl/square_unit_pipe.sv | 203 ++++++++++++++++++++
 tb/tb_square_unit_pipe.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/square_unit_pipe_if.sv
// Move stream between a board cell and the array collector.
// The cell drives valid/data; the collector drives ready.
interface square_unit_pipe_if #(
  parameter int MOVE_W = 19
) ();
  logic              mv_valid;
  logic [MOVE_W-1:0] mv_data;
  logic              mv_ready;

  modport master (output mv_valid, output mv_data, input mv_ready);
  modport slave  (input mv_valid, input mv_data, output mv_ready);
endinterface

// File: rtl/square_unit_pipe.sv
// Per-square move-generation cell: GEN, PROP sweeps and a knight phase feed an 8-slot pending bank.
// Step results land on the accepting edge; moves drain lowest slot first, held while mv_ready=0.
module square_unit_pipe #(
  parameter int COORD_W    = 3,
  parameter int PROP_STEPS = (1 << COORD_W) - 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [COORD_W-1:0]             xpos,
  input  logic [COORD_W-1:0]             ypos,
  input  logic [3:0]                     cpiece,
  input  logic                           side,
  input  logic                           start,
  input  logic                           step,
  input  logic [8*(2*COORD_W+3)-1:0]     ray_in,
  output logic [8*(2*COORD_W+3)-1:0]     ray_out,
  input  logic [8*(2*COORD_W+3)-1:0]     kn_in,
  output logic [8*(2*COORD_W+3)-1:0]     kn_out,
  square_unit_pipe_if.master             mv,
  output logic                           busy,
  output logic                           done,
  output logic                           err_overrun
);
  localparam int TOK_W  = 2*COORD_W + 3;
  localparam int MOVE_W = 7 + 4*COORD_W;
  localparam int CNT_W  = (PROP_STEPS > 1) ? $clog2(PROP_STEPS) : 1;

  typedef enum logic [2:0] {S_IDLE, S_GEN, S_PROP, S_KNI, S_DRAIN, S_DONE} state_t;
  typedef struct packed {
    logic       mv;
    logic       fw;
    logic [6:0] fl;
  } prop_res_t;

  state_t             state, state_nxt;
  logic               side_q;
  logic [CNT_W-1:0]   prop_cnt;
  logic [7:0]         pend_vld;
  logic [MOVE_W-1:0]  pend_dat [8];

  logic               sq_empty, sq_own, sq_enemy;
  logic               start_acc, step_acc, pop;
  logic [2:0]         sel;
  logic [7:0]         pop_mask;
  logic [TOK_W-1:0]   here_tok;
  logic [7:0]         gen_mask;
  logic               gen_kn_en;
  logic [8*TOK_W-1:0] gen_ray, gen_kn, prop_ray;
  prop_res_t          pr [8];
  logic [7:0]         prop_vld, kni_vld;
  logic [MOVE_W-1:0]  prop_dat [8];
  logic [MOVE_W-1:0]  kni_dat [8];

  // Flags are {invalid, promote, pawn, pawn2, ep, castle, capture}.
  function automatic prop_res_t prop_eval(input logic [TOK_W-1:0] tok, input logic [2:0] dir,
                                          input logic is_empty, input logic is_enemy,
                                          input logic sd, input logic [COORD_W-1:0] y);
    prop_res_t          res;
    logic [2:0]         ty;
    logic [COORD_W-1:0] oy, dy;
    logic               pawn, fwd, promo, start_rk;
    res      = '0;
    ty       = tok[2:0];
    oy       = tok[3 +: COORD_W];
    dy       = (y >= oy) ? (y - oy) : (oy - y);
    pawn     = (ty == 3'd1);
    fwd      = (dir == (sd ? 3'd4 : 3'd0));
    promo    = (y == {COORD_W{~sd}});
    start_rk = (oy == (sd ? ~COORD_W'(1) : COORD_W'(1)));
    if (ty != 3'd0) begin
      if (is_empty) begin
        if (!pawn) begin
          res.mv = 1'b1;
        end else if (fwd) begin
          res.mv    = 1'b1;
          res.fl[4] = 1'b1;
          res.fl[3] = (dy == COORD_W'(2));
          res.fl[5] = promo;
        end
        res.fw = (ty == 3'd3 && dir[0]) || (ty == 3'd4 && !dir[0]) || (ty == 3'd5) ||
                 (pawn && fwd && start_rk && dy == COORD_W'(1));
      end else if (is_enemy && !(pawn && fwd)) begin
        res.mv    = 1'b1;
        res.fl[0] = 1'b1;
        res.fl[4] = pawn;
        res.fl[5] = pawn && promo;
      end
    end
    return res;
  endfunction

  assign sq_empty  = (cpiece[2:0] == 3'd0);
  assign sq_own    = !sq_empty && (cpiece[3] == side_q);
  assign sq_enemy  = !sq_empty && (cpiece[3] != side_q);
  assign busy      = |pend_vld;
  assign start_acc = start && (state == S_IDLE || state == S_DONE);
  assign step_acc  = step && !start && !busy;
  assign pop       = busy && mv.mv_ready;
  assign here_tok  = {xpos, ypos, cpiece[2:0]};

  always_comb begin
    sel = '0;
    for (int i = 7; i >= 0; i--) begin
      if (pend_vld[i]) sel = 3'(i);
    end
    pop_mask = pop ? (8'b1 << sel) : 8'b0;
  end

  assign mv.mv_valid = busy;
  assign mv.mv_data  = pend_dat[sel];

  always_comb begin
    gen_mask  = '0;
    gen_kn_en = 1'b0;
    if (sq_own) begin
      case (cpiece[2:0])
        3'd1:       gen_mask  = side_q ? 8'b0011_1000 : 8'b1000_0011;
        3'd2:       gen_kn_en = 1'b1;
        3'd3:       gen_mask  = 8'b1010_1010;
        3'd4:       gen_mask  = 8'b0101_0101;
        3'd5, 3'd6: gen_mask  = 8'hff;
        default:    gen_mask  = '0;
      endcase
    end
    for (int d = 0; d < 8; d++) begin
      gen_ray[d*TOK_W +: TOK_W] = gen_mask[d] ? here_tok : '0;
    end
    gen_kn = gen_kn_en ? {8{here_tok}} : '0;
  end

  always_comb begin
    for (int d = 0; d < 8; d++) begin
      pr[d] = prop_eval(ray_in[d*TOK_W +: TOK_W], 3'(d), sq_empty, sq_enemy, side_q, ypos);
      prop_ray[d*TOK_W +: TOK_W] = pr[d].fw ? ray_in[d*TOK_W +: TOK_W] : '0;
      prop_vld[d] = pr[d].mv;
      prop_dat[d] = {pr[d].fl, ray_in[d*TOK_W+3 +: 2*COORD_W], xpos, ypos};
      kni_vld[d]  = (|kn_in[d*TOK_W +: TOK_W]) && (sq_empty || sq_enemy);
      kni_dat[d]  = {6'b0, sq_enemy, kn_in[d*TOK_W+3 +: 2*COORD_W], xpos, ypos};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    case (state)
      S_IDLE:  if (start_acc) state_nxt = S_GEN;
      S_GEN:   if (step_acc) state_nxt = S_PROP;
      S_PROP:  if (step_acc && prop_cnt == CNT_W'(PROP_STEPS - 1)) state_nxt = S_KNI;
      S_KNI:   if (step_acc) state_nxt = S_DRAIN;
      S_DRAIN: if ((pend_vld & ~pop_mask) == 8'b0) state_nxt = S_DONE;
      S_DONE: begin
        done = 1'b1;
        if (start_acc) state_nxt = S_GEN;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Steps only load into an empty bank, so a load never races a pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      side_q      <= 1'b0;
      prop_cnt    <= '0;
      ray_out     <= '0;
      kn_out      <= '0;
      pend_vld    <= '0;
      err_overrun <= 1'b0;
      for (int i = 0; i < 8; i++) pend_dat[i] <= '0;
    end else begin
      if (step && busy) err_overrun <= 1'b1;
      if (pop) pend_vld[sel] <= 1'b0;
      if (start_acc) begin
        side_q   <= side;
        prop_cnt <= '0;
      end else if (step_acc) begin
        case (state)
          S_GEN: begin
            ray_out <= gen_ray;
            kn_out  <= gen_kn;
          end
          S_PROP: begin
            ray_out  <= prop_ray;
            prop_cnt <= prop_cnt + 1'b1;
            pend_vld <= prop_vld;
            for (int i = 0; i < 8; i++) pend_dat[i] <= prop_dat[i];
          end
          S_KNI: begin
            ray_out  <= '0;
            kn_out   <= '0;
            pend_vld <= kni_vld;
            for (int i = 0; i < 8; i++) pend_dat[i] <= kni_dat[i];
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_square_unit_pipe.sv
// Scoreboard bench for square_unit_pipe: expected moves queued at each step, compared as they drain.
module tb_square_unit_pipe;
  localparam int MW = 19;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  xpos, ypos;
  logic [3:0]  cpiece;
  logic        side, start, step;
  logic [71:0] ray_in, ray_out, kn_in, kn_out;
  logic        busy, done, err_overrun;

  square_unit_pipe_if #(.MOVE_W(MW)) mv ();

  square_unit_pipe #(.COORD_W(3)) dut (
    .clk(clk), .reset(reset), .xpos(xpos), .ypos(ypos), .cpiece(cpiece), .side(side),
    .start(start), .step(step), .ray_in(ray_in), .ray_out(ray_out), .kn_in(kn_in),
    .kn_out(kn_out), .mv(mv), .busy(busy), .done(done), .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  logic [MW-1:0] sb[$];
  int n_cmp = 0, n_err = 0, n_exp = 0, n_rx = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [MW-1:0] mk_mv(input logic [6:0] fl, input logic [5:0] from,
                                          input logic [5:0] to);
    return {fl, from, to};
  endfunction

  function automatic logic [71:0] one_tok(input int d, input logic [8:0] t);
    logic [71:0] b;
    b = '0;
    b[d*9 +: 9] = t;
    return b;
  endfunction

  task automatic push(input logic [MW-1:0] m);
    sb.push_back(m);
    n_exp++;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic pulse_step();
    @(posedge clk); #1 step = 1'b1;
    @(posedge clk); #1 step = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 reset = 1'b1;
    n_exp -= sb.size();
    sb.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int k;
    k = 0;
    while (busy && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    check(tag, busy, 1'b0);
  endtask

  always @(negedge clk) begin
    if (!reset && mv.mv_valid && mv.mv_ready) begin
      n_rx++;
      if (sb.size() > 0) check("mv_data", mv.mv_data, sb.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [71:0] exp_bus;
    xpos = 3'd0; ypos = 3'd0; cpiece = 4'd0; side = 1'b0;
    start = 1'b0; step = 1'b0; ray_in = '0; kn_in = '0;
    mv.mv_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_ray", ray_out, 72'd0);
    check("rst_kn", kn_out, 72'd0);
    check("rst_valid", mv.mv_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err_overrun, 1'b0);

    // White rook radiates orthogonally on GEN, then its own square emits nothing.
    cpiece = 4'b0100; xpos = 3'd3; ypos = 3'd3; side = 1'b0;
    pulse_start();
    pulse_step();
    exp_bus = one_tok(0, 9'o334) | one_tok(2, 9'o334) | one_tok(4, 9'o334) | one_tok(6, 9'o334);
    check("rook_gen_ray", ray_out, exp_bus);
    check("rook_gen_kn", kn_out, 72'd0);
    @(negedge clk);
    check("rook_gen_nomv", mv.mv_valid, 1'b0);
    pulse_step();
    check("rook_prop_clear", ray_out, 72'd0);

    // White knight: all knight outputs, held across a PROP step.
    do_reset();
    cpiece = 4'b0010; xpos = 3'd1; ypos = 3'd0;
    pulse_start();
    pulse_step();
    check("kn_gen", kn_out, {8{9'o102}});
    check("kn_gen_ray", ray_out, 72'd0);
    pulse_step();
    check("kn_hold", kn_out, {8{9'o102}});

    // White pawn pushes: single (forwarded), double, promotion.
    do_reset();
    cpiece = 4'b0000; xpos = 3'd4; ypos = 3'd2;
    pulse_start();
    pulse_step();
    ray_in = one_tok(0, 9'o411);
    push(mk_mv(7'b0010000, 6'o41, 6'o42));
    pulse_step();
    check("pawn1_fwd", ray_out, one_tok(0, 9'o411));
    wait_drain("pawn1_drain");
    ypos = 3'd3;
    push(mk_mv(7'b0011000, 6'o41, 6'o43));
    pulse_step();
    check("pawn2_nofwd", ray_out, 72'd0);
    wait_drain("pawn2_drain");
    xpos = 3'd0; ypos = 3'd7;
    ray_in = one_tok(0, 9'o061);
    push(mk_mv(7'b0110000, 6'o06, 6'o07));
    pulse_step();
    check("promo_nofwd", ray_out, 72'd0);
    ray_in = '0;
    wait_drain("promo_drain");

    // Black pawn travels south and is forwarded from its start rank.
    do_reset();
    side = 1'b1; xpos = 3'd2; ypos = 3'd5;
    pulse_start();
    pulse_step();
    ray_in = one_tok(4, 9'o261);
    push(mk_mv(7'b0010000, 6'o26, 6'o25));
    pulse_step();
    ray_in = '0;
    check("bpawn_fwd", ray_out, one_tok(4, 9'o261));
    wait_drain("bpawn_drain");

    // Enemy knight: bishop captures, pawn straight ahead is blocked.
    do_reset();
    side = 1'b0; cpiece = 4'b1010; xpos = 3'd2; ypos = 3'd2;
    pulse_start();
    pulse_step();
    ray_in = one_tok(0, 9'o211) | one_tok(1, 9'o113);
    push(mk_mv(7'b0000001, 6'o11, 6'o22));
    pulse_step();
    ray_in = '0;
    check("cap_nofwd", ray_out, 72'd0);
    wait_drain("cap_drain");

    // Knight phase with backpressure, then drain and done.
    do_reset();
    cpiece = 4'b0000; xpos = 3'd5; ypos = 3'd5;
    pulse_start();
    repeat (8) pulse_step();
    check("kni_pre_busy", busy, 1'b0);
    kn_in = one_tok(1, 9'o432) | one_tok(4, 9'o342) | one_tok(6, 9'o672);
    mv.mv_ready = 1'b0;
    push(mk_mv(7'b0, 6'o43, 6'o55));
    push(mk_mv(7'b0, 6'o34, 6'o55));
    push(mk_mv(7'b0, 6'o67, 6'o55));
    pulse_step();
    kn_in = '0;
    check("kni_kn_clear", kn_out, 72'd0);
    check("kni_ray_clear", ray_out, 72'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      check("kni_hold_valid", mv.mv_valid, 1'b1);
      check("kni_hold_data", mv.mv_data, sb[0]);
      check("kni_hold_done", done, 1'b0);
    end
    @(posedge clk); #1 mv.mv_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("kni_consec", sb.size(), 0);
    check("kni_done_early", done, 1'b0);
    @(posedge clk); #1;
    check("kni_busy_drop", busy, 1'b0);
    check("kni_done", done, 1'b1);

    // Step while busy is dropped and flagged; reset mid-PROP clears everything.
    do_reset();
    xpos = 3'd4; ypos = 3'd2;
    pulse_start();
    pulse_step();
    mv.mv_ready = 1'b0;
    ray_in = one_tok(0, 9'o411);
    push(mk_mv(7'b0010000, 6'o41, 6'o42));
    pulse_step();
    ray_in = one_tok(2, 9'o014);
    pulse_step();
    ray_in = '0;
    check("ovr_err", err_overrun, 1'b1);
    check("ovr_ray", ray_out, one_tok(0, 9'o411));
    check("ovr_busy", busy, 1'b1);
    check("ovr_data", mv.mv_data, mk_mv(7'b0010000, 6'o41, 6'o42));
    @(posedge clk); #1 reset = 1'b1;
    #1;
    check("arst_ray", ray_out, 72'd0);
    check("arst_kn", kn_out, 72'd0);
    check("arst_valid", mv.mv_valid, 1'b0);
    check("arst_busy", busy, 1'b0);
    check("arst_done", done, 1'b0);
    check("arst_err", err_overrun, 1'b0);
    n_exp -= sb.size();
    sb.delete();
    mv.mv_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);

    check("mv_count", n_rx, n_exp);
    check("sb_left", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
